serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor; the inverse operation of the team's 4-bit ripple adder.
- Computes diff = a - b one bit per clock, LSB first, with a start/busy/done handshake.
- Used where area matters more than latency, and as a cross-check for the adder: (a + b) - b must equal a.
- Operands are captured on start, so the source may change a/b while the block is busy.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Request/response bundle for the bit-serial subtractor: operands and start in,
// busy/done handshake and registered result out.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b computed LSB first, one bit per
// clock, with operands captured on the accepting start edge.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             br;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt;
  logic             x;
  logic             y;
  logic             d;
  logic             br_next;
  logic             last;

  always_comb begin
    x       = a_sr[0];
    y       = b_sr[0];
    d       = x ^ y ^ br;
    br_next = (~x & y) | (~(x ^ y) & br);
    last    = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last)      state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      br       <= 1'b0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            diff_sr  <= '0;
            br       <= 1'b0;
            borrow_q <= 1'b0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          // Each result bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
          diff_sr <= {d, diff_sr[WIDTH-1:1]};
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          br      <= br_next;
          cnt     <= cnt + 1'b1;
          if (last) borrow_q <= br_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.diff   = diff_sr;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;
  localparam int          LAT   = WIDTH;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             br;
    int               acc;
    string            tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t q[$];

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input int ta, input int tb, input int acc, input string tag);
    exp_t e;
    e.d   = WIDTH'((ta - tb + (1 << WIDTH)) % (1 << WIDTH));
    e.br  = (ta < tb);
    e.acc = acc;
    e.tag = tag;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, "_diff"},    int'(bus.diff),   int'(e.d));
        chk({e.tag, "_borrow"},  int'(bus.borrow), int'(e.br));
        chk({e.tag, "_latency"}, cyc - e.acc,      LAT);
        chk({e.tag, "_busy"},    int'(bus.busy),   1);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) chk("idle_timeout", int'(bus.busy), 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input string tag);
    wait_idle();
    bus.a     = ta;
    bus.b     = tb;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    q.push_back(model(int'(ta), int'(tb), cyc, tag));
    chk({tag, "_accept_busy"}, int'(bus.busy), 1);
    chk({tag, "_accept_clr"},  int'({bus.diff, bus.borrow}), 0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",   int'(bus.busy),   0);
    chk("reset_done",   int'(bus.done),   0);
    chk("reset_diff",   int'(bus.diff),   0);
    chk("reset_borrow", int'(bus.borrow), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'b0000, 4'b0000, "zero");
    do_op(4'b1111, 4'b0001, "f_minus_1");
    do_op(4'b1010, 4'b1010, "equal");
    do_op(4'b0000, 4'b0001, "underflow");
    do_op(4'b0101, 4'b1010, "5_minus_a");
    do_op(4'b1000, 4'b1011, "8_minus_b");

    // Start while busy must be ignored, operands already captured.
    wait_idle();
    bus.a = 4'b0011; bus.b = 4'b1100; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    q.push_back(model(3, 12, cyc, "busy_start"));
    @(negedge clk);
    bus.a = 4'b1110; bus.b = 4'b0001; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);

    // Held start: accepted again at the first idle edge, WIDTH+2 cycles later.
    wait_idle();
    bus.a = 4'b1111; bus.b = 4'b0101; bus.start = 1'b1;
    @(negedge clk);
    q.push_back(model(15, 5, cyc, "held_1"));
    repeat (WIDTH + 2) @(negedge clk);
    bus.start = 1'b0;
    q.push_back(model(15, 5, cyc, "held_2"));
    chk("held_2_clr", int'({bus.diff, bus.borrow}), 0);
    chk("held_2_busy", int'(bus.busy), 1);
    wait_drain();

    // Reset during SHIFT aborts without a done pulse.
    wait_idle();
    bus.a = 4'b1001; bus.b = 4'b0100; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy",   int'(bus.busy),   0);
    chk("abort_done",   int'(bus.done),   0);
    chk("abort_diff",   int'(bus.diff),   0);
    chk("abort_borrow", int'(bus.borrow), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_op(4'b0110, 4'b0011, "post_reset");

    for (int i = 0; i < 40; i++) begin
      do_op(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)),
            WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), "rand");
    end

    repeat (8) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
